// File: rtl/slice_loader_if.sv
// slice_loader_if: slice stream from the producer plus the encoder handoff
// signals. The master side is the environment (stream source and encoder);
// the slave side is the loader.
interface slice_loader_if #(
    parameter int unsigned NUM_SLICES = 64,
    parameter int unsigned SLICE_W    = 25
);
    localparam int unsigned NUM_CELLS = NUM_SLICES * SLICE_W;

    logic                 in_valid;
    logic                 in_ready;
    logic [SLICE_W-1:0]   in_slice;
    logic                 in_last;
    logic                 enc_start;
    logic [NUM_CELLS-1:0] enc_data;
    logic                 enc_done;
    logic                 busy;
    logic                 err;

    modport master (
        output in_valid, in_slice, in_last, enc_done,
        input  in_ready, enc_start, enc_data, busy, err
    );

    modport slave (
        input  in_valid, in_slice, in_last, enc_done,
        output in_ready, enc_start, enc_data, busy, err
    );
endinterface

// File: rtl/slice_loader.sv
// slice_loader: collects NUM_SLICES slices of SLICE_W bits into a holding
// register, pulses enc_start once the frame is complete, then stalls the
// stream until a rising edge of enc_done.
// Optional feature macro: SLICE_LOADER_LAST_CHECK_EN enables in_last framing
// checks with a one-cycle err pulse; without it in_last is ignored and err is 0.
module slice_loader #(
    parameter int unsigned NUM_SLICES = 64,
    parameter int unsigned SLICE_W    = 25
) (
    input logic          clk,
    input logic          rst,
    slice_loader_if.slave bus
);
    localparam int unsigned NUM_CELLS = NUM_SLICES * SLICE_W;
    localparam int unsigned CNT_W     = $clog2(NUM_SLICES);
    localparam int unsigned IDX_W     = $clog2(NUM_CELLS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {StFill, StStart, StWait} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q;
    logic                 err_q, err_d;
    logic [NUM_CELLS-1:0] data_q;
    logic                 beat;
    logic                 last_slot;
    logic [IDX_W-1:0]     slot_lsb;

    // Ready is a pure decode of state (plus reset), never of in_valid.
    assign bus.in_ready  = (state_q == StFill) & ~rst;
    assign bus.enc_start = (state_q == StStart);
    assign bus.busy      = (state_q == StWait);
    assign bus.enc_data  = data_q;
    assign bus.err       = err_q;

    assign beat      = bus.in_valid & bus.in_ready;
    assign last_slot = (cnt_q == CNT_MAX);
    // Slot 0 sits at the MSB end of the block.
    assign slot_lsb  = IDX_W'((NUM_SLICES - 1 - 32'(cnt_q)) * SLICE_W);

`ifndef SLICE_LOADER_LAST_CHECK_EN
    logic unused_in_last;
    assign unused_in_last = bus.in_last;
`endif

    // State, counter, done edge detector and error pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFill;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= bus.enc_done;
            err_q   <= err_d;
        end
    end

    // Holding register: written only on accepted beats, so frozen in START/WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (beat) begin
            data_q[slot_lsb +: SLICE_W] <= bus.in_slice;
        end
    end

    // Next-state, slot counter and framing-error decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            StFill: begin
                if (beat) begin
`ifdef SLICE_LOADER_LAST_CHECK_EN
                    // in_last must be set on the final slot and only there.
                    if (bus.in_last != last_slot) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else if (last_slot) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    if (last_slot) begin
                        state_d = StStart;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                // Edge, not level: a done left high from the last frame is ignored.
                if (bus.enc_done & ~done_q) begin
                    state_d = StFill;
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end
endmodule

// File: tb/tb_slice_loader.sv
// tb_slice_loader: directed stimulus with a scoreboard. The stimulus process
// queues the expected handoff blocks and error pulses; a monitor pops and
// compares whenever the DUT raises enc_start or err.
module tb_slice_loader;
    localparam int NS = 64;
    localparam int SW = 25;
    localparam int NC = NS * SW;
`ifdef SLICE_LOADER_LAST_CHECK_EN
    localparam int EXP_ERRS = 2;
`else
    localparam int EXP_ERRS = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    slice_loader_if #(.NUM_SLICES(NS), .SLICE_W(SW)) bus ();

    slice_loader #(.NUM_SLICES(NS), .SLICE_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int err_cnt = 0;
    logic start_prev = 1'b0;
    logic err_prev = 1'b0;
    logic [NC-1:0] exp_q[$];
    int err_q[$];

    function automatic logic [SW-1:0] gen(int kind, int i);
        logic [4:0] v;
        if (kind == 0) begin
            v = 5'(31 - (i % 32));
            return {5{v}};
        end
        return SW'(i * 32'h51 + kind * 32'h0ABCDE);
    endfunction

    function automatic logic [NC-1:0] frame(int kind);
        logic [NC-1:0] f;
        f = '0;
        for (int i = 0; i < NS; i++) f[NC-1-i*SW -: SW] = gen(kind, i);
        return f;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic chk_data(string name, logic [NC-1:0] got, logic [NC-1:0] want);
        int bad;
        bad = -1;
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            for (int i = NS - 1; i >= 0; i--)
                if (got[NC-1-i*SW -: SW] !== want[NC-1-i*SW -: SW]) bad = i;
            if (bad < 0) bad = 0;
            $display("FAIL %s: slot %0d got %h want %h", name, bad,
                     got[NC-1-bad*SW -: SW], want[NC-1-bad*SW -: SW]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(logic [SW-1:0] s, logic last);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_slice = s;
        bus.in_last  = last;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL beat_timeout: in_ready got 0 want 1");
        end else begin
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Lower done, then raise it; the loader must reopen within a few cycles.
    task automatic done_handshake();
        int n;
        n = 0;
        bus.enc_done = 1'b0;
        tick();
        tick();
        bus.enc_done = 1'b1;
        while (!bus.in_ready && n < 10) begin
            tick();
            n++;
        end
        chk("done_release_ready", 32'(bus.in_ready), 1);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (bus.enc_start) begin
            start_cnt++;
            chk("start_width", 32'(start_prev), 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_start: got enc_start want no pending frame");
            end else begin
                chk_data("handoff_data", bus.enc_data, exp_q.pop_front());
            end
        end
        if (bus.err) begin
            err_cnt++;
            if (err_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_err: got err=1 want 0");
            end else begin
                void'(err_q.pop_front());
                chk("err_width", 32'(err_prev), 0);
            end
        end
        start_prev = bus.enc_start;
        err_prev   = bus.err;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_slice = '0;
        bus.in_last  = 1'b0;
        bus.enc_done = 1'b0;
        rst = 1'b1;

        // Reset for three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_enc_start", 32'(bus.enc_start), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk_data("rst_enc_data", bus.enc_data, '0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.in_ready), 1);
        tick();

        // Frame A, back-to-back, with a stale done level held high.
        bus.enc_done = 1'b1;
        exp_q.push_back(frame(0));
        for (int i = 0; i < NS; i++) send_beat(gen(0, i), i == NS - 1);
        bus.in_valid = 1'b1;
        bus.in_slice = 25'h0AAAAAA;
        @(negedge clk);
        chk("ready_in_start", 32'(bus.in_ready), 0);
        repeat (5) tick();
        @(negedge clk);
        chk("wait_stale_done_busy", 32'(bus.busy), 1);
        chk("wait_stale_done_ready", 32'(bus.in_ready), 0);
        chk("a_slot0", 32'(bus.enc_data[1599:1575]), 32'h1FFFFFF);
        chk("a_slot62", 32'(bus.enc_data[49:25]), 32'h0108421);
        chk("a_slot63", 32'(bus.enc_data[24:0]), 32'h0);
        chk("starts_a", 32'(start_cnt), 1);
        tick();
        bus.in_valid = 1'b0;
        bus.enc_done = 1'b0;
        tick();
        tick();
        bus.enc_done = 1'b1;
        @(negedge clk);
        chk("wait_before_rise", 32'(bus.busy), 1);
        @(negedge clk);
        chk("fill_after_rise_ready", 32'(bus.in_ready), 1);
        chk("fill_after_rise_busy", 32'(bus.busy), 0);
        chk_data("data_held_through_wait", bus.enc_data, frame(0));
        tick();

        // Frame B with in_valid toggling every cycle for 128 cycles.
        begin
            int idx;
            idx = 0;
            exp_q.push_back(frame(1));
            for (int c = 0; c < 128; c++) begin
                if (c % 2 == 0) begin
                    bus.in_valid = 1'b1;
                    bus.in_slice = gen(1, idx);
                    bus.in_last  = (idx == NS - 1);
                    idx++;
                end else begin
                    bus.in_valid = 1'b0;
                    bus.in_last  = 1'b0;
                end
                tick();
            end
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("starts_b", 32'(start_cnt), 2);
        chk("busy_b", 32'(bus.busy), 1);
        tick();
        done_handshake();

        // Reset after 40 beats, then a clean frame D.
        bus.enc_done = 1'b0;
        for (int i = 0; i < 40; i++) send_beat(gen(2, i), 1'b0);
        rst = 1'b1;
        tick();
        chk("ready_in_reset", 32'(bus.in_ready), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_data("data_cleared_by_reset", bus.enc_data, '0);
        chk("starts_after_abort", 32'(start_cnt), 2);
        tick();
        exp_q.push_back(frame(3));
        for (int i = 0; i < NS; i++) send_beat(gen(3, i), i == NS - 1);
        @(negedge clk);
        #1;
        chk("starts_d", 32'(start_cnt), 3);
        tick();
        done_handshake();

        // Framing: in_last on beat 10.
`ifdef SLICE_LOADER_LAST_CHECK_EN
        for (int i = 0; i <= 10; i++) begin
            if (i == 10) err_q.push_back(1);
            send_beat(gen(4, i), i == 10);
        end
        for (int i = 0; i < NS; i++) begin
            if (i == NS - 1) err_q.push_back(1);
            send_beat(gen(5, i), 1'b0);
        end
        @(negedge clk);
        #1;
        chk("starts_after_bad_frames", 32'(start_cnt), 3);
        tick();
        exp_q.push_back(frame(6));
        for (int i = 0; i < NS; i++) send_beat(gen(6, i), i == NS - 1);
`else
        exp_q.push_back(frame(4));
        for (int i = 0; i < NS; i++) send_beat(gen(4, i), i == 10);
`endif
        @(negedge clk);
        #1;
        chk("starts_framing", 32'(start_cnt), 4);
        tick();
        done_handshake();
        repeat (3) tick();

        chk("err_pulses", 32'(err_cnt), 32'(EXP_ERRS));
        chk("frames_pending", 32'(exp_q.size()), 0);
        chk("errs_pending", 32'(err_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
